// File: rtl/uvme_clk_st_freq_chkr_pkg.sv
// Shared types, default parameters and arithmetic helpers for the clock-frequency checker.
package uvme_clk_st_freq_chkr_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ACQ     = 2'd1,
    RUN     = 2'd2,
    STOPPED = 2'd3
  } chan_state_t;

  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_ERR_CNT_W = 8;
  localparam int DEF_TIMEOUT   = 1000;
  localparam int DEF_LOCK_CNT  = 4;

  // abs_diff runs at the widest supported counter width; callers zero-extend into it.
  localparam int MAX_CNT_W = 32;

  function automatic logic [MAX_CNT_W:0] abs_diff(input logic [MAX_CNT_W-1:0] a,
                                                  input logic [MAX_CNT_W-1:0] b);
    logic [MAX_CNT_W:0] ax;
    logic [MAX_CNT_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return (ax >= bx) ? (ax - bx) : (bx - ax);
  endfunction

endpackage

// File: rtl/uvme_clk_st_freq_chkr_chan.sv
// One monitored-clock channel: synchroniser, edge detect, period counter, FSM,
// lock tracking and saturating error counter.
module uvme_clk_st_freq_chkr_chan
  import uvme_clk_st_freq_chkr_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int LOCK_CNT  = DEF_LOCK_CNT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mon_clk_i,
  input  logic                 en_i,
  input  logic [CNT_W-1:0]     exp_period_i,
  input  logic [CNT_W-1:0]     tol_i,
  input  logic                 clr_i,
  output logic [CNT_W-1:0]     period_o,
  output logic                 period_vld_o,
  output logic                 err_o,
  output logic                 locked_o,
  output logic                 stopped_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int                 MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LOCK_C    = MATCH_W'(LOCK_CNT);

  chan_state_t        state_q, state_d;
  logic               mon_p0, mon_p1, mon_p2;
  logic               rise;
  logic               in_tol;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   period_d;
  logic               vld_d, err_d, locked_d, stopped_d;

  // mon_p0/mon_p1 form the synchroniser; mon_p2 delays for edge detection.
  assign rise   = mon_p1 & ~mon_p2;
  assign in_tol = abs_diff(MAX_CNT_W'(cnt_q), MAX_CNT_W'(exp_period_i))
                  <= (MAX_CNT_W + 1)'(tol_i);

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    period_d  = period_o;
    locked_d  = locked_o;
    stopped_d = stopped_o;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    if (rise)               cnt_d = CNT_W'(1);
    else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;

    if (!en_i) begin
      state_d   = OFF;
      cnt_d     = '0;
      match_d   = '0;
      locked_d  = 1'b0;
      stopped_d = 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = ACQ;
          cnt_d   = '0;
        end
        ACQ: begin
          if (rise) begin
            state_d = RUN;
          end else if (cnt_q == TIMEOUT_C) begin
            state_d   = STOPPED;
            stopped_d = 1'b1;
            err_d     = 1'b1;
          end
        end
        RUN: begin
          if (rise) begin
            period_d = cnt_q;
            vld_d    = 1'b1;
            if (in_tol) begin
              if (match_q != LOCK_C) match_d = match_q + 1'b1;
              if (match_d == LOCK_C) locked_d = 1'b1;
            end else begin
              err_d    = 1'b1;
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            state_d   = STOPPED;
            stopped_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            err_d     = 1'b1;
          end
        end
        STOPPED: begin
          // The period spanning the outage is meaningless, so this rise only re-arms.
          if (rise) begin
            state_d   = RUN;
            stopped_d = 1'b0;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_p0       <= 1'b0;
      mon_p1       <= 1'b0;
      mon_p2       <= 1'b0;
      state_q      <= OFF;
      cnt_q        <= '0;
      match_q      <= '0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
      err_o        <= 1'b0;
      locked_o     <= 1'b0;
      stopped_o    <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      mon_p0       <= mon_clk_i;
      mon_p1       <= mon_p0;
      mon_p2       <= mon_p1;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      period_o     <= period_d;
      period_vld_o <= vld_d;
      err_o        <= err_d;
      locked_o     <= locked_d;
      stopped_o    <= stopped_d;
      if (clr_i)                          err_cnt_o <= '0;
      else if (err_o && err_cnt_o != '1)  err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/uvme_clk_st_freq_chkr.sv
// Multi-channel clock-frequency checker: one independent checker per monitored clock.
module uvme_clk_st_freq_chkr
  import uvme_clk_st_freq_chkr_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int LOCK_CNT  = DEF_LOCK_CNT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           mon_clk_i,
  input  logic [NUM_CH-1:0]           en_i,
  input  logic [NUM_CH*CNT_W-1:0]     exp_period_i,
  input  logic [CNT_W-1:0]            tol_i,
  input  logic                        clr_i,
  output logic [NUM_CH*CNT_W-1:0]     period_o,
  output logic [NUM_CH-1:0]           period_vld_o,
  output logic [NUM_CH-1:0]           err_o,
  output logic [NUM_CH-1:0]           locked_o,
  output logic [NUM_CH-1:0]           stopped_o,
  output logic [NUM_CH*ERR_CNT_W-1:0] err_cnt_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uvme_clk_st_freq_chkr_chan #(
      .CNT_W     (CNT_W),
      .ERR_CNT_W (ERR_CNT_W),
      .TIMEOUT   (TIMEOUT),
      .LOCK_CNT  (LOCK_CNT)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .mon_clk_i    (mon_clk_i[i]),
      .en_i         (en_i[i]),
      .exp_period_i (exp_period_i[i*CNT_W +: CNT_W]),
      .tol_i        (tol_i),
      .clr_i        (clr_i),
      .period_o     (period_o[i*CNT_W +: CNT_W]),
      .period_vld_o (period_vld_o[i]),
      .err_o        (err_o[i]),
      .locked_o     (locked_o[i]),
      .stopped_o    (stopped_o[i]),
      .err_cnt_o    (err_cnt_o[i*ERR_CNT_W +: ERR_CNT_W])
    );
  end

endmodule
